// File: rtl/logic_pkg.sv
// Shared constants for the sliced bitwise logic sequencer.
// Op codes, FSM state encoding and datapath width.
package logic_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise op on one SLICE_W-bit slice.
// NOT ignores operand b.
module logic_slice
    import logic_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [1:0]         op,
    output logic [SLICE_W-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_seq.sv
// Multi-cycle bitwise logic unit: processes SLICE_W bits per RUN
// cycle, LSB first, with valid/ready request and response handshakes.
module logic_seq
    import logic_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        busy
);

    localparam int NSL = DATA_W / SLICE_W;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);
    localparam logic [DATA_W-1:0] SMASK = DATA_W'({SLICE_W{1'b1}});

    generate
        if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 ||
              SLICE_W == 8 || SLICE_W == 16 || SLICE_W == 32)) begin : g_bad_w
            $error("logic_seq: illegal SLICE_W");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic [5:0]          off;
    logic [DATA_W-1:0]   a_sh, b_sh, r_ext;
    logic [SLICE_W-1:0]  r_sl;

    // Bit offset of the current slice; never exceeds 31.
    assign off  = 6'(cnt_q) * 6'(SLICE_W);
    assign a_sh = a_q >> off;
    assign b_sh = b_q >> off;

    logic_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a      (a_sh[SLICE_W-1:0]),
        .b      (b_sh[SLICE_W-1:0]),
        .op     (op_q),
        .result (r_sl)
    );

    assign r_ext = DATA_W'(r_sl);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        op_d    = req_op;
                        res_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    res_d = (res_q & ~(SMASK << off)) | (r_ext << off);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = res_q;
    assign rsp_zero  = (res_q == '0);

endmodule

// File: tb/tb_logic_seq.sv
// Directed self-checking bench for logic_seq at SLICE_W = 8, 1 and 32.
// Expected values are hand-computed constants.
module tb_logic_seq;
    import logic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_zero, busy;
    logic [31:0] rsp_data;

    logic        v1 = 1'b0, v32 = 1'b0;
    logic        rr1 = 1'b1, rr32 = 1'b1;
    logic        qr1, rv1, rz1, bz1;
    logic        qr32, rv32, rz32, bz32;
    logic [31:0] rd1, rd32;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic_seq #(.SLICE_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
    );

    logic_seq #(.SLICE_W(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(v1), .req_ready(qr1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_data(rd1), .rsp_zero(rz1), .busy(bz1)
    );

    logic_seq #(.SLICE_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(v32), .req_ready(qr32),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rv32), .rsp_ready(rr32),
        .rsp_data(rd32), .rsp_zero(rz32), .busy(bz32)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Accept one request on the main DUT and wait for rsp_valid.
    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, lat1, lat32, cyc;
        logic [31:0] d1, d32, held;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 1);
        chk("rst_busy", busy, 0);

        // AND with rsp_ready held high
        send(OP_AND, 32'hF0F0_1234, 32'hFF00_00FF, lat);
        chk("and_lat", 32'(lat), 4);
        chk("and_data", rsp_data, 32'hF000_0034);
        chk("and_zero", rsp_zero, 0);
        chk("and_req_ready_done", req_ready, 0);
        @(posedge clk); #1;
        chk("and_idle", busy, 0);

        send(OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat);
        chk("xor_data", rsp_data, 0);
        chk("xor_zero", rsp_zero, 1);
        @(posedge clk); #1;

        send(OP_NOT, 32'h0000_0000, 32'h1234_5678, lat);
        chk("not_data", rsp_data, 32'hFFFF_FFFF);
        chk("not_zero", rsp_zero, 0);
        @(posedge clk); #1;

        send(OP_OR, 32'h1200_0034, 32'h0056_7800, lat);
        chk("or_data", rsp_data, 32'h1256_7834);
        @(posedge clk); #1;

        // Backpressure: result held for 10 cycles, new request refused
        rsp_ready = 1'b0;
        send(OP_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, lat);
        held = 32'hAAAA_AAAA;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, held);
            chk("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_valid_last", rsp_valid, 1);
        @(posedge clk); #1;
        chk("bp_hs_valid", rsp_valid, 0);
        chk("bp_hs_idle", req_ready, 1);
        @(posedge clk); #1;
        chk("bp_single_hs", busy, 0);

        // Flush after two slices
        req_op = OP_AND;
        req_a = 32'hFFFF_FFFF;
        req_b = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_req_ready", req_ready, 1);
        chk("flush_rsp_valid", rsp_valid, 0);
        send(OP_OR, 32'h0000_FFFF, 32'hFFFF_0000, lat);
        chk("flush_or_lat", 32'(lat), 4);
        chk("flush_or_data", rsp_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Flush wins over a request being accepted
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b0;
        chk("flush_accept_busy", busy, 0);

        // Reset while holding a result in DONE
        rsp_ready = 1'b0;
        send(OP_NOT, 32'h0000_00FF, 32'h0, lat);
        chk("rst_done_valid_pre", rsp_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("rst_done_req_ready", req_ready, 1);
        chk("rst_done_rsp_valid", rsp_valid, 0);
        chk("rst_done_data", rsp_data, 0);
        chk("rst_done_zero", rsp_zero, 1);
        send(OP_OR, 32'h0000_FFFF, 32'hFFFF_0000, lat);
        chk("rst_or_data", rsp_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Slice widths 1 and 32
        req_op = OP_OR;
        req_a = 32'h0000_FFFF;
        req_b = 32'hFFFF_0000;
        v1 = 1'b1;
        v32 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        v32 = 1'b0;
        lat1 = 0;
        lat32 = 0;
        d1 = '0;
        d32 = '0;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (rv1 && lat1 == 0) begin
                lat1 = cyc;
                d1 = rd1;
            end
            if (rv32 && lat32 == 0) begin
                lat32 = cyc;
                d32 = rd32;
            end
        end
        chk("w1_lat", 32'(lat1), 32);
        chk("w1_data", d1, 32'hFFFF_FFFF);
        chk("w32_lat", 32'(lat32), 1);
        chk("w32_data", d32, 32'hFFFF_FFFF);
        chk("w1_idle", bz1, 0);
        chk("w32_idle", bz32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
